// File: rtl/mau_pkg.sv
// mau_pkg: FSM state encoding and access-type constants shared by the arbiter files.
package mau_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_ACK   = 2'd3
    } mau_state_e;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

endpackage

// File: rtl/mau_port_arbiter_if.sv
// mau_port_arbiter_if: two request ports plus the synchronous RAM port.
// The slave modport is the arbiter; the master modport is the requester/RAM side.
interface mau_port_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
);
    logic                  req0_enable;
    logic                  req0_rw;
    logic [ADDR_W-1:0]     req0_address;
    logic [DATA_W/8-1:0]   req0_byte_enable;
    logic [DATA_W-1:0]     req0_write_data;
    logic [DATA_W-1:0]     req0_read_data;
    logic                  req0_acknowledge;

    logic                  req1_enable;
    logic                  req1_rw;
    logic [ADDR_W-1:0]     req1_address;
    logic [DATA_W/8-1:0]   req1_byte_enable;
    logic [DATA_W-1:0]     req1_write_data;
    logic [DATA_W-1:0]     req1_read_data;
    logic                  req1_acknowledge;

    logic [ADDR_W-1:0]     mem_address;
    logic [DATA_W-1:0]     mem_write_data;
    logic [DATA_W/8-1:0]   mem_byte_en;
    logic                  mem_wren;
    logic [DATA_W-1:0]     mem_read_data;

    modport slave (
        input  req0_enable, req0_rw, req0_address, req0_byte_enable, req0_write_data,
        output req0_read_data, req0_acknowledge,
        input  req1_enable, req1_rw, req1_address, req1_byte_enable, req1_write_data,
        output req1_read_data, req1_acknowledge,
        output mem_address, mem_write_data, mem_byte_en, mem_wren,
        input  mem_read_data
    );

    modport master (
        output req0_enable, req0_rw, req0_address, req0_byte_enable, req0_write_data,
        input  req0_read_data, req0_acknowledge,
        output req1_enable, req1_rw, req1_address, req1_byte_enable, req1_write_data,
        input  req1_read_data, req1_acknowledge,
        input  mem_address, mem_write_data, mem_byte_en, mem_wren,
        output mem_read_data
    );

endinterface

// File: rtl/mau_rr_picker.sv
// mau_rr_picker: combinational winner selection between two requesters.
// Under contention the requester that was not granted last wins; grant 0 selects requester 0.
module mau_rr_picker (
    input  logic req0,
    input  logic req1,
    input  logic last_grant,
    output logic grant
);

    // Winner selection
    always_comb begin
        grant = 1'b0;
        if (req0 && req1) begin
            grant = ~last_grant;
        end else if (req1) begin
            grant = 1'b1;
        end else begin
            grant = 1'b0;
        end
    end

endmodule

// File: rtl/mau_port_arbiter.sv
// mau_port_arbiter: arbitrates two requesters onto one 1-cycle-latency synchronous RAM port.
// Define MAU_ARB_ROUND_ROBIN_EN for alternating grants; otherwise requester 0 has fixed priority.
module mau_port_arbiter
    import mau_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    mau_port_arbiter_if.slave bus
);

    localparam int BE_W = DATA_W / 8;

    mau_state_e        state_r;
    mau_state_e        state_s;

    logic              req_any_s;
    logic              grant_s;
    logic              pick_last_s;
    logic              take_s;
    logic              done_s;

    logic              sel_rw_s;
    logic [ADDR_W-1:0] sel_addr_s;
    logic [BE_W-1:0]   sel_be_s;
    logic [DATA_W-1:0] sel_wdata_s;

    logic              winner_r;
    logic              rw_r;
    logic [ADDR_W-1:0] addr_r;
    logic [BE_W-1:0]   be_r;
    logic [DATA_W-1:0] wdata_r;
    logic [DATA_W-1:0] rdata0_r;
    logic [DATA_W-1:0] rdata1_r;

    logic              wren_s;
    logic              ack0_s;
    logic              ack1_s;
    logic              wren_r;
    logic              ack0_r;
    logic              ack1_r;

    assign req_any_s = bus.req0_enable | bus.req1_enable;

    mau_rr_picker u_picker (
        .req0       (bus.req0_enable),
        .req1       (bus.req1_enable),
        .last_grant (pick_last_s),
        .grant      (grant_s)
    );

`ifdef MAU_ARB_ROUND_ROBIN_EN
    logic last_grant_r;

    // Last-grant history; reset value 1 lets requester 0 win the first contention
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_r <= 1'b1;
        end else if (take_s) begin
            last_grant_r <= grant_s;
        end
    end

    assign pick_last_s = last_grant_r;
`else
    assign pick_last_s = 1'b1;
`endif

    // Route the winning requester's fields toward the request latch
    always_comb begin
        sel_rw_s    = bus.req0_rw;
        sel_addr_s  = bus.req0_address;
        sel_be_s    = bus.req0_byte_enable;
        sel_wdata_s = bus.req0_write_data;
        if (grant_s) begin
            sel_rw_s    = bus.req1_rw;
            sel_addr_s  = bus.req1_address;
            sel_be_s    = bus.req1_byte_enable;
            sel_wdata_s = bus.req1_write_data;
        end else begin
            sel_rw_s    = bus.req0_rw;
            sel_addr_s  = bus.req0_address;
            sel_be_s    = bus.req0_byte_enable;
            sel_wdata_s = bus.req0_write_data;
        end
    end

    // Next state plus the next values of the registered strobes
    always_comb begin
        state_s = state_r;
        take_s  = 1'b0;
        done_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (req_any_s) begin
                    state_s = ST_ISSUE;
                    take_s  = 1'b1;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (rw_r == RW_READ) begin
                    state_s = ST_WAIT;
                end else begin
                    state_s = ST_ACK;
                    done_s  = 1'b1;
                end
            end
            ST_WAIT: begin
                state_s = ST_ACK;
                done_s  = 1'b1;
            end
            ST_ACK: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
        // Strobes are registered one cycle early so they line up with ISSUE and ACK
        wren_s = take_s && (sel_rw_s == RW_WRITE);
        ack0_s = done_s && !winner_r;
        ack1_s = done_s && winner_r;
    end

    // FSM state and one-cycle strobes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            wren_r  <= 1'b0;
            ack0_r  <= 1'b0;
            ack1_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            wren_r  <= wren_s;
            ack0_r  <= ack0_s;
            ack1_r  <= ack1_s;
        end
    end

    // Request latch, loaded only when IDLE accepts a request
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            winner_r <= 1'b0;
            rw_r     <= 1'b0;
            addr_r   <= {ADDR_W{1'b0}};
            be_r     <= {BE_W{1'b0}};
            wdata_r  <= {DATA_W{1'b0}};
        end else if (take_s) begin
            winner_r <= grant_s;
            rw_r     <= sel_rw_s;
            addr_r   <= sel_addr_s;
            be_r     <= sel_be_s;
            wdata_r  <= sel_wdata_s;
        end
    end

    // Per-requester read-data capture; RAM data is valid during WAIT
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata0_r <= {DATA_W{1'b0}};
            rdata1_r <= {DATA_W{1'b0}};
        end else if (state_r == ST_WAIT) begin
            if (winner_r) begin
                rdata1_r <= bus.mem_read_data;
            end else begin
                rdata0_r <= bus.mem_read_data;
            end
        end
    end

    assign bus.mem_address      = addr_r;
    assign bus.mem_write_data   = wdata_r;
    assign bus.mem_byte_en      = be_r;
    assign bus.mem_wren         = wren_r;
    assign bus.req0_acknowledge = ack0_r;
    assign bus.req1_acknowledge = ack1_r;
    assign bus.req0_read_data   = rdata0_r;
    assign bus.req1_read_data   = rdata1_r;

endmodule

// File: tb/tb_mau_port_arbiter.sv
// tb_mau_port_arbiter: directed-vector bench for mau_port_arbiter with a behavioural 1-cycle RAM.
// Contention expectations follow whether MAU_ARB_ROUND_ROBIN_EN is defined for the build.
module tb_mau_port_arbiter;
    import mau_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    mau_port_arbiter_if #(.ADDR_W(16), .DATA_W(32)) bus ();

    mau_port_arbiter #(.ADDR_W(16), .DATA_W(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [31:0] ram [0:255] = '{default: 32'h0};

    // Synchronous RAM: byte-masked write, registered read
    always @(posedge clk) begin
        if (bus.mem_wren) begin
            for (int b = 0; b < 4; b++) begin
                if (bus.mem_byte_en[b]) ram[bus.mem_address[7:0]][b*8 +: 8] <= bus.mem_write_data[b*8 +: 8];
            end
        end
        bus.mem_read_data <= ram[bus.mem_address[7:0]];
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit n, input logic en, input logic rw, input logic [15:0] a,
                         input logic [3:0] be, input logic [31:0] wd);
        if (n) begin
            bus.req1_enable = en; bus.req1_rw = rw; bus.req1_address = a;
            bus.req1_byte_enable = be; bus.req1_write_data = wd;
        end else begin
            bus.req0_enable = en; bus.req0_rw = rw; bus.req0_address = a;
            bus.req0_byte_enable = be; bus.req0_write_data = wd;
        end
    endtask

    // One transaction; returns ack latency (-1 on timeout) and what the RAM port saw
    task automatic txn(input bit n, input logic rw, input logic [15:0] a, input logic [3:0] be,
                       input logic [31:0] wd, output int lat, output int wcnt,
                       output logic [15:0] wa, output logic [31:0] wdat, output logic [3:0] wbe,
                       output bit other_ack);
        drive(n, 1'b1, rw, a, be, wd);
        lat = -1; wcnt = 0; wa = 16'h0; wdat = 32'h0; wbe = 4'h0; other_ack = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (bus.mem_wren) begin
                wcnt++; wa = bus.mem_address; wdat = bus.mem_write_data; wbe = bus.mem_byte_en;
            end
            if (n ? bus.req0_acknowledge : bus.req1_acknowledge) other_ack = 1'b1;
            if (n ? bus.req1_acknowledge : bus.req0_acknowledge) begin
                lat = k;
                break;
            end
        end
        drive(n, 1'b0, rw, a, be, wd);
    endtask

    int          lat, wcnt, nack, ngrant;
    logic [15:0] wa;
    logic [31:0] wdat;
    logic [3:0]  wbe;
    bit          oth;
    logic [7:0]  amask, wmask;
    logic [3:0]  grants, exp_grants;

    initial begin
        rst_n = 1'b0;
        drive(1'b0, 1'b0, RW_READ, 16'h0, 4'h0, 32'h0);
        drive(1'b1, 1'b0, RW_READ, 16'h0, 4'h0, 32'h0);
        repeat (2) @(negedge clk);
        chk("rst_ack0", 64'(bus.req0_acknowledge), 64'h0);
        chk("rst_ack1", 64'(bus.req1_acknowledge), 64'h0);
        chk("rst_wren", 64'(bus.mem_wren), 64'h0);
        chk("rst_addr", 64'(bus.mem_address), 64'h0);
        chk("rst_rd0", 64'(bus.req0_read_data), 64'h0);
        chk("rst_rd1", 64'(bus.req1_read_data), 64'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single write from requester 1
        txn(1'b1, RW_WRITE, 16'h0020, 4'hF, 32'h12345678, lat, wcnt, wa, wdat, wbe, oth);
        chk("wr1_lat", 64'(lat), 64'd2);
        chk("wr1_wcnt", 64'(wcnt), 64'd1);
        chk("wr1_addr", 64'(wa), 64'h0020);
        chk("wr1_data", 64'(wdat), 64'h12345678);
        chk("wr1_be", 64'(wbe), 64'hF);
        chk("wr1_other", 64'(oth), 64'h0);
        @(negedge clk);
        chk("wr1_ack_width", 64'(bus.req1_acknowledge), 64'h0);
        chk("wr1_wren_after", 64'(bus.mem_wren), 64'h0);

        // Load 0xDEADBEEF at 0x0010, then read it back through requester 0
        txn(1'b0, RW_WRITE, 16'h0010, 4'hF, 32'hDEADBEEF, lat, wcnt, wa, wdat, wbe, oth);
        chk("wr0_lat", 64'(lat), 64'd2);
        @(negedge clk);
        txn(1'b0, RW_READ, 16'h0010, 4'h0, 32'h0, lat, wcnt, wa, wdat, wbe, oth);
        chk("rd0_lat", 64'(lat), 64'd3);
        chk("rd0_wcnt", 64'(wcnt), 64'd0);
        chk("rd0_data", 64'(bus.req0_read_data), 64'hDEADBEEF);
        chk("rd0_other", 64'(oth), 64'h0);
        @(negedge clk);
        chk("rd0_ack_width", 64'(bus.req0_acknowledge), 64'h0);
        chk("rd0_hold", 64'(bus.req0_read_data), 64'hDEADBEEF);

        // Zero byte-enable write still strobes and acks, leaves RAM and read data alone
        txn(1'b0, RW_WRITE, 16'h0010, 4'h0, 32'hFFFFFFFF, lat, wcnt, wa, wdat, wbe, oth);
        chk("zbe_lat", 64'(lat), 64'd2);
        chk("zbe_wcnt", 64'(wcnt), 64'd1);
        chk("zbe_be", 64'(wbe), 64'h0);
        chk("zbe_rd_hold", 64'(bus.req0_read_data), 64'hDEADBEEF);
        @(negedge clk);
        txn(1'b1, RW_READ, 16'h0010, 4'h0, 32'h0, lat, wcnt, wa, wdat, wbe, oth);
        chk("zbe_rd1_lat", 64'(lat), 64'd3);
        chk("zbe_rd1_data", 64'(bus.req1_read_data), 64'hDEADBEEF);
        chk("zbe_rd0_untouched", 64'(bus.req0_read_data), 64'hDEADBEEF);
        @(negedge clk);

        // Back-to-back writes with req0 held: acks at +2 and +5, wren at +1 and +4
        drive(1'b0, 1'b1, RW_WRITE, 16'h0030, 4'hF, 32'hA5A5A5A5);
        amask = 8'h0; wmask = 8'h0; nack = 0; oth = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            if (bus.req0_acknowledge) begin
                amask[k] = 1'b1;
                nack++;
                if (nack == 2) bus.req0_enable = 1'b0;
            end
            if (bus.mem_wren) wmask[k] = 1'b1;
            if (bus.req1_acknowledge) oth = 1'b1;
        end
        bus.req0_enable = 1'b0;
        chk("b2b_ack_mask", 64'(amask), 64'h24);
        chk("b2b_wren_mask", 64'(wmask), 64'h12);
        chk("b2b_other", 64'(oth), 64'h0);

        // Reset asserted while a read sits in WAIT
        drive(1'b0, 1'b1, RW_READ, 16'h0020, 4'h0, 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ack0", 64'(bus.req0_acknowledge), 64'h0);
        chk("mid_rst_ack1", 64'(bus.req1_acknowledge), 64'h0);
        chk("mid_rst_wren", 64'(bus.mem_wren), 64'h0);
        chk("mid_rst_addr", 64'(bus.mem_address), 64'h0);
        chk("mid_rst_wdata", 64'(bus.mem_write_data), 64'h0);
        chk("mid_rst_rd0", 64'(bus.req0_read_data), 64'h0);
        chk("mid_rst_rd1", 64'(bus.req1_read_data), 64'h0);
        bus.req0_enable = 1'b0;
        repeat (2) @(negedge clk);
        chk("mid_rst_no_ack", 64'(bus.req0_acknowledge), 64'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // Contention: both held, four grants recorded (bit i = requester of grant i)
        drive(1'b0, 1'b1, RW_READ, 16'h0010, 4'h0, 32'h0);
        drive(1'b1, 1'b1, RW_READ, 16'h0020, 4'h0, 32'h0);
        grants = 4'h0; ngrant = 0;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (bus.req0_acknowledge && ngrant < 4) begin
                grants[ngrant] = 1'b0; ngrant++;
            end else if (bus.req1_acknowledge && ngrant < 4) begin
                grants[ngrant] = 1'b1; ngrant++;
            end
            if (ngrant == 4) begin
                bus.req0_enable = 1'b0;
                bus.req1_enable = 1'b0;
                break;
            end
        end
        bus.req0_enable = 1'b0;
        bus.req1_enable = 1'b0;
`ifdef MAU_ARB_ROUND_ROBIN_EN
        exp_grants = 4'b1010;
`else
        exp_grants = 4'b0000;
`endif
        chk("cont_count", 64'(ngrant), 64'd4);
        chk("cont_order", 64'(grants), 64'(exp_grants));
        chk("cont_rd0", 64'(bus.req0_read_data), 64'hDEADBEEF);
        @(negedge clk);

        // Requester 1 is served once requester 0 is quiet
        txn(1'b1, RW_READ, 16'h0020, 4'h0, 32'h0, lat, wcnt, wa, wdat, wbe, oth);
        chk("solo1_lat", 64'(lat), 64'd3);
        chk("solo1_data", 64'(bus.req1_read_data), 64'h12345678);
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mau_port_arbiter.md
MAU_PORT_ARBITER -- requirements
Module: mau_port_arbiter

Interface
REQ-001 Parameter ADDR_W, default 16, SHALL set the memory word-address width.
REQ-002 Parameter DATA_W, default 32, SHALL set the data width; byte-enable width SHALL be DATA_W/8.
REQ-003 Port clk, input, 1, SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 Port rst_n, input, 1, SHALL be the asynchronous active-low reset.
REQ-005 Ports reqN_enable (N=0,1), input, 1, SHALL carry the request strobe, held until acknowledge.
REQ-006 Ports reqN_rw, input, 1, SHALL select the access type: 1 = read, 0 = write.
REQ-007 Ports reqN_address, input, ADDR_W, SHALL carry the word address.
REQ-008 Ports reqN_byte_enable, input, DATA_W/8, SHALL carry the write byte enables.
REQ-009 Ports reqN_write_data, input, DATA_W, SHALL carry the write data.
REQ-010 Ports reqN_read_data, output, DATA_W, SHALL return read data, valid while reqN_acknowledge is 1.
REQ-011 Ports reqN_acknowledge, output, 1, SHALL carry the one-cycle completion pulse.
REQ-012 Ports mem_address/mem_write_data/mem_byte_en/mem_wren, outputs, ADDR_W/DATA_W/DATA_W/8/1, SHALL drive one synchronous RAM port with 1-cycle read latency.
REQ-013 Port mem_read_data, input, DATA_W, SHALL carry RAM read data.

Function
REQ-014 The FSM SHALL have four states: IDLE, ISSUE, WAIT and ACK.
REQ-015 In IDLE, when any reqN_enable is 1, the block SHALL pick a winner, register the winner's rw, address, byte_enable and write_data, and go to ISSUE.
REQ-016 In ISSUE, mem_address, mem_byte_en and mem_write_data SHALL come from registers; mem_wren SHALL be 1 only for a write, for exactly this one cycle.
REQ-017 From ISSUE, a write SHALL go to ACK and a read SHALL go to WAIT.
REQ-018 In WAIT, mem_read_data SHALL be captured into the read-data register, then the FSM SHALL go to ACK.
REQ-019 In ACK, only the winner's acknowledge SHALL be 1, for exactly one cycle; the FSM SHALL then go to IDLE.
REQ-020 Latency, counted from the IDLE cycle that samples the request: write ack at cycle +2, read ack at cycle +3.
REQ-021 Request inputs SHALL be ignored outside IDLE.
REQ-022 A reqN_enable still high on the IDLE cycle after ACK SHALL be treated as a new request.
REQ-023 The non-winning requester SHALL wait, unacknowledged, with no loss of its request.
REQ-024 A write with byte_enable 0000 SHALL still pulse mem_wren and be acknowledged.
REQ-025 reqN_read_data SHALL hold its last captured value; writes SHALL NOT update it.
REQ-026 mem_wren SHALL never be 1 outside ISSUE.

Reset
REQ-027 While rst_n=0: state=IDLE, mem_wren=0, both acknowledges=0, and all address/data/read-data registers=0.
REQ-028 Reset asserted mid-transaction SHALL abort the transaction immediately: no ack, no further mem_wren.
REQ-029 The last-grant register SHALL reset to 1, so requester 0 wins the first contention.

Configuration
REQ-030 With MAU_ARB_ROUND_ROBIN_EN defined, simultaneous requests SHALL be granted to the requester not granted last; the last-grant register SHALL update on every grant.
REQ-031 Without MAU_ARB_ROUND_ROBIN_EN, requester 0 SHALL always win contention, and the last-grant register SHALL be absent.

Structure
REQ-032 Package mau_pkg SHALL hold the FSM state encoding and the RW_READ/RW_WRITE constants.
REQ-033 Winner selection SHALL live in a combinational sub-module, mau_rr_picker (inputs: two requests and the last grant; output: the grant index).

Verification
REQ-034 Single read: req0 rw=1, addr 0x0010, RAM word 0xDEADBEEF -> req0_acknowledge pulses at cycle +3 with req0_read_data=0xDEADBEEF.
REQ-035 Single write: req1 rw=0, addr 0x0020, data 0x12345678, be 1111 -> exactly one mem_wren cycle with matching address/data; ack at cycle +2.
REQ-036 Contention, round-robin built: both requesters held high for 4 transactions -> grant order 0,1,0,1; without the macro, requester 0 wins every time until it drops its request.
REQ-037 Reset mid-read: rst_n low during WAIT -> no acknowledge, mem_wren=0, and all outputs at reset values the same cycle.
REQ-038 Zero byte-enable write: be 0000 -> mem_wren pulses with mem_byte_en=0000 and ack at cycle +2; a following read returns the unchanged RAM word.
REQ-039 Back-to-back: req0 held high after ack -> a second transaction starts on the next IDLE cycle, and every ack is exactly one cycle wide.
